// File: rtl/rate_strobe_gen_if.sv
// rtl/rate_strobe_gen_if.sv - control/status bundle for the fractional rate strobe generator
//
// Purpose: groups the rate-control inputs and the strobe/phase outputs of
// rate_strobe_gen so the generator and its user connect through one port.
//
// Signals:
//   enable       master->slave  1        1: accumulate, 0: hold state
//   sync_clr     master->slave  1        pulse: clear accumulator (phase realign)
//   inc_i        master->slave  ACC_W    new increment value
//   inc_load     master->slave  1        pulse: capture inc_i as pending increment
//   strobe_o     slave->master  1        1-cycle sample strobe
//   phase_o      slave->master  PHASE_W  fractional phase captured at each strobe
//   load_busy_o  slave->master  1        pending increment not yet applied
//   strobe_cnt_o slave->master  CNT_W    wrapping strobe count
interface rate_strobe_gen_if #(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 16,
  parameter int CNT_W   = 16
);
  logic               enable;
  logic               sync_clr;
  logic [ACC_W-1:0]   inc_i;
  logic               inc_load;
  logic               strobe_o;
  logic [PHASE_W-1:0] phase_o;
  logic               load_busy_o;
  logic [CNT_W-1:0]   strobe_cnt_o;

  modport master (
    output enable,
    output sync_clr,
    output inc_i,
    output inc_load,
    input  strobe_o,
    input  phase_o,
    input  load_busy_o,
    input  strobe_cnt_o
  );

  modport slave (
    input  enable,
    input  sync_clr,
    input  inc_i,
    input  inc_load,
    output strobe_o,
    output phase_o,
    output load_busy_o,
    output strobe_cnt_o
  );
endinterface

// File: rtl/rate_strobe_gen.sv
// rtl/rate_strobe_gen.sv - NCO-based fractional sample-rate strobe generator
//
// Purpose: a phase accumulator adds the current increment every enabled
// cycle; each overflow produces a registered one-cycle strobe, captures the
// accumulator MSBs as the fractional phase for the interpolator and bumps a
// wrapping strobe counter. Mean strobe rate is inc/2^ACC_W of clk.
// New increments are held pending and only take effect on a strobe boundary
// (or while disabled), so rate switches never produce a short/long glitch
// period.
//
// Ports:
//   clk   in  1   system clock
//   rst   in  1   synchronous reset, active-high, dominates everything
//   bus   slave modport of rate_strobe_gen_if (controls in, strobe/phase/status out)
module rate_strobe_gen #(
  parameter int               ACC_W   = 32,
  parameter int               PHASE_W = 16,
  parameter int               CNT_W   = 16,
  parameter logic [ACC_W-1:0] DEF_INC = ACC_W'(32'h4000_0000)
) (
  input  logic                clk,
  input  logic                rst,
  rate_strobe_gen_if.slave    bus
);

  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   inc_cur_q;
  logic [ACC_W-1:0]   inc_pend_q;
  logic               pend_q;
  logic               strobe_q;
  logic [PHASE_W-1:0] phase_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [ACC_W:0]     sum;
  logic               accum;
  logic               carry;
  logic               apply;

  // One extra bit on the sum gives the overflow (carry) directly.
  assign sum   = {1'b0, acc_q} + {1'b0, inc_cur_q};
  // sync_clr wins over accumulation, so a clear edge never carries.
  assign accum = bus.enable & ~bus.sync_clr;
  assign carry = accum & sum[ACC_W];
  // Swap increments only at a strobe boundary or while the NCO is parked;
  // the accumulation that produced this carry still used the old increment.
  assign apply = pend_q & (carry | ~bus.enable);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      inc_cur_q  <= DEF_INC;
      inc_pend_q <= '0;
      pend_q     <= 1'b0;
      strobe_q   <= 1'b0;
      phase_q    <= '0;
      cnt_q      <= '0;
    end else begin
      if (bus.sync_clr) begin
        acc_q    <= '0;
        strobe_q <= 1'b0;
      end else if (bus.enable) begin
        acc_q    <= sum[ACC_W-1:0];
        strobe_q <= carry;
        if (carry) begin
          phase_q <= sum[ACC_W-1 -: PHASE_W];
          cnt_q   <= cnt_q + CNT_W'(1);
        end
      end else begin
        strobe_q <= 1'b0;
      end

      if (apply) begin
        inc_cur_q <= inc_pend_q;
      end

      // A load on the apply edge re-arms pending with the new value; the
      // value just applied is the one captured earlier.
      if (bus.inc_load) begin
        inc_pend_q <= bus.inc_i;
        pend_q     <= 1'b1;
      end else if (apply) begin
        pend_q     <= 1'b0;
      end
    end
  end

  assign bus.strobe_o     = strobe_q;
  assign bus.phase_o      = phase_q;
  assign bus.load_busy_o  = pend_q;
  assign bus.strobe_cnt_o = cnt_q;

endmodule
